// File: rtl/microcode_sequencer.sv
// Microcode sequencer: expands decoded instructions into (cnt+1) micro-ops read from an
// asynchronous microcode ROM and issues them through a one-entry valid/ready output register.
module microcode_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int CNT_W    = 3,
  parameter int DATA_W   = 32,
  parameter logic [ADDR_W-1:0] NOP_ADDR = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_pipeline,
  input  logic              dec_valid,
  input  logic [91:0]       idecode_cu_interface,
  output logic              cu_ready,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              uop_valid,
  input  logic              uop_ready,
  output logic [DATA_W-1:0] uop_word,
  output logic [ADDR_W-1:0] uop_addr,
  output logic              uop_last,
  output logic [31:0]       uop_instr,
  output logic [16:0]       uop_br_info
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              uop_valid_q, uop_valid_d;
  logic              uop_last_q, uop_last_d;
  logic [DATA_W-1:0] uop_word_q, uop_word_d;
  logic [ADDR_W-1:0] uop_addr_q, uop_addr_d;
  logic [31:0]       uop_instr_q, uop_instr_d;
  logic [16:0]       uop_br_info_q, uop_br_info_d;

  logic [31:0]       dec_instr;
  logic [ADDR_W-1:0] dec_uc_addr;
  logic [CNT_W-1:0]  dec_uc_cnt;
  logic [16:0]       dec_br_info;
  logic              slot_free;
  logic              accept;
  logic              unused_bits;

  assign dec_instr   = idecode_cu_interface[31:0];
  assign dec_uc_addr = idecode_cu_interface[39:32];
  assign dec_uc_cnt  = idecode_cu_interface[42:40];
  assign dec_br_info = {idecode_cu_interface[91], idecode_cu_interface[90:83],
                        idecode_cu_interface[82:75]};
  assign unused_bits = ^idecode_cu_interface[74:43];

  assign slot_free = !uop_valid_q || uop_ready;
  assign cu_ready  = (state_q == IDLE) && slot_free && !flush_pipeline;
  assign accept    = cu_ready && dec_valid && (dec_uc_addr != NOP_ADDR);
  assign rom_addr  = (state_q == IDLE) ? dec_uc_addr : upc_q;

  // Instruction and branch fields stay in the output register for the whole sequence,
  // so the RUN path only replaces word/address/last.
  always_comb begin
    state_d       = state_q;
    upc_d         = upc_q;
    remaining_d   = remaining_q;
    uop_valid_d   = uop_valid_q;
    uop_last_d    = uop_last_q;
    uop_word_d    = uop_word_q;
    uop_addr_d    = uop_addr_q;
    uop_instr_d   = uop_instr_q;
    uop_br_info_d = uop_br_info_q;

    if (flush_pipeline) begin
      state_d     = IDLE;
      uop_valid_d = 1'b0;
      remaining_d = '0;
    end else if (state_q == IDLE) begin
      if (accept) begin
        uop_valid_d   = 1'b1;
        uop_word_d    = rom_data;
        uop_addr_d    = dec_uc_addr;
        uop_last_d    = (dec_uc_cnt == '0);
        uop_instr_d   = dec_instr;
        uop_br_info_d = dec_br_info;
        if (dec_uc_cnt != '0) begin
          upc_d       = dec_uc_addr + ADDR_W'(1);
          remaining_d = dec_uc_cnt;
          state_d     = RUN;
        end
      end else if (slot_free) begin
        uop_valid_d = 1'b0;
      end
    end else if (slot_free) begin
      uop_valid_d = 1'b1;
      uop_word_d  = rom_data;
      uop_addr_d  = upc_q;
      uop_last_d  = (remaining_q == CNT_W'(1));
      upc_d       = upc_q + ADDR_W'(1);
      remaining_d = remaining_q - CNT_W'(1);
      if (remaining_q == CNT_W'(1)) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      upc_q         <= '0;
      remaining_q   <= '0;
      uop_valid_q   <= 1'b0;
      uop_last_q    <= 1'b0;
      uop_word_q    <= '0;
      uop_addr_q    <= '0;
      uop_instr_q   <= '0;
      uop_br_info_q <= '0;
    end else begin
      state_q       <= state_d;
      upc_q         <= upc_d;
      remaining_q   <= remaining_d;
      uop_valid_q   <= uop_valid_d;
      uop_last_q    <= uop_last_d;
      uop_word_q    <= uop_word_d;
      uop_addr_q    <= uop_addr_d;
      uop_instr_q   <= uop_instr_d;
      uop_br_info_q <= uop_br_info_d;
    end
  end

  assign uop_valid   = uop_valid_q;
  assign uop_last    = uop_last_q;
  assign uop_word    = uop_word_q;
  assign uop_addr    = uop_addr_q;
  assign uop_instr   = uop_instr_q;
  assign uop_br_info = uop_br_info_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Scoreboard bench for microcode_sequencer: a queue of outstanding micro-ops is the reference
// model; a negedge monitor compares the DUT output register and cu_ready against it.
module tb_microcode_sequencer;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] word;
    logic        last;
    logic [31:0] instr;
    logic [16:0] br;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush_pipeline;
  logic        dec_valid;
  logic [91:0] idecode_cu_interface;
  logic        cu_ready;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        uop_valid;
  logic        uop_ready;
  logic [31:0] uop_word;
  logic [7:0]  uop_addr;
  logic        uop_last;
  logic [31:0] uop_instr;
  logic [16:0] uop_br_info;

  logic [31:0] rom_mem [256];
  exp_t        exp_q[$];
  int          checks;
  int          failures;
  logic        mon_en;

  microcode_sequencer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .flush_pipeline      (flush_pipeline),
    .dec_valid           (dec_valid),
    .idecode_cu_interface(idecode_cu_interface),
    .cu_ready            (cu_ready),
    .rom_addr            (rom_addr),
    .rom_data            (rom_data),
    .uop_valid           (uop_valid),
    .uop_ready           (uop_ready),
    .uop_word            (uop_word),
    .uop_addr            (uop_addr),
    .uop_last            (uop_last),
    .uop_instr           (uop_instr),
    .uop_br_info         (uop_br_info)
  );

  assign rom_data = rom_mem[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sequencer can take a new instruction only once nothing beyond the register remains.
  function automatic logic model_ready();
    return !flush_pipeline &&
           ((exp_q.size() == 0) || ((exp_q.size() == 1) && uop_ready));
  endfunction

  function automatic exp_t make_entry(input logic [7:0] a, input logic lst);
    exp_t e;
    e.addr  = a;
    e.word  = rom_mem[a];
    e.last  = lst;
    e.instr = idecode_cu_interface[31:0];
    e.br    = {idecode_cu_interface[91], idecode_cu_interface[90:83],
               idecode_cu_interface[82:75]};
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: an accepted instruction contributes cnt+1 consecutive ROM words.
  always @(posedge clk) begin
    if (!rst_n || flush_pipeline) begin
      exp_q.delete();
    end else if (model_ready() && dec_valid && (idecode_cu_interface[39:32] != 8'hFF)) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      for (int k = 0; k <= int'(idecode_cu_interface[42:40]); k++)
        exp_q.push_back(make_entry(idecode_cu_interface[39:32] + 8'(k),
                                   k == int'(idecode_cu_interface[42:40])));
    end else if ((exp_q.size() != 0) && uop_ready) begin
      void'(exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      checkOutput("uop_valid", 64'(uop_valid), 64'(exp_q.size() != 0));
      checkOutput("cu_ready", 64'(cu_ready), 64'(model_ready()));
      if (exp_q.size() != 0) begin
        checkOutput("uop_addr", 64'(uop_addr), 64'(exp_q[0].addr));
        checkOutput("uop_word", 64'(uop_word), 64'(exp_q[0].word));
        checkOutput("uop_last", 64'(uop_last), 64'(exp_q[0].last));
        checkOutput("uop_instr", 64'(uop_instr), 64'(exp_q[0].instr));
        checkOutput("uop_br_info", 64'(uop_br_info), 64'(exp_q[0].br));
      end
    end
  end

  task automatic applyStimulus(input logic dv, input logic [7:0] addr, input logic [2:0] cnt,
                               input logic rdy, input logic fl);
    dec_valid            = dv;
    idecode_cu_interface = {$urandom, $urandom, $urandom};
    idecode_cu_interface[39:32] = addr;
    idecode_cu_interface[42:40] = cnt;
    uop_ready      = rdy;
    flush_pipeline = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_uop_valid", 64'(uop_valid), 64'd0);
    checkOutput("rst_uop_last", 64'(uop_last), 64'd0);
    checkOutput("rst_uop_word", 64'(uop_word), 64'd0);
    checkOutput("rst_uop_addr", 64'(uop_addr), 64'd0);
    checkOutput("rst_uop_instr", 64'(uop_instr), 64'd0);
    checkOutput("rst_uop_br_info", 64'(uop_br_info), 64'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;
    for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'h05, 3'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h05, 3'd1, 1'b1, 1'b0);
    checkResetOutputs();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    $display("[TB] single-word instruction");
    applyStimulus(1'b1, 8'h00, 3'd0, 1'b1, 1'b0);
    idle(3);

    $display("[TB] multi-word instruction");
    applyStimulus(1'b1, 8'h07, 3'd2, 1'b1, 1'b0);
    idle(4);

    $display("[TB] back-pressure");
    applyStimulus(1'b1, 8'h3A, 3'd4, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h20, 3'd0, 1'b0, 1'b0);
    idle(6);

    $display("[TB] flush");
    applyStimulus(1'b1, 8'h0A, 3'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h30, 3'd0, 1'b1, 1'b1);
    idle(3);

    $display("[TB] NOP address");
    applyStimulus(1'b1, 8'hFF, 3'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hFF, 3'd3, 1'b1, 1'b0);
    idle(2);

    $display("[TB] reset mid-sequence");
    applyStimulus(1'b1, 8'h10, 3'd4, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    checkResetOutputs();
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'hFE, 3'd3, 1'b1, 1'b0);
    idle(5);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      applyStimulus($urandom_range(0, 1) == 1,
                    ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom),
                    3'($urandom), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 24) == 0);
    end
    rst_n = 1'b1;
    idle(12);
    checkOutput("drained", 64'(uop_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
